// File: rtl/fx_select_xfade.sv
// fx_select_xfade: selects one of NUM_FX effect outputs with a linear crossfade on change, then blends dry/wet.
module fx_select_xfade #(
  parameter int NUM_FX = 4,
  parameter int CHANNELS = 2,
  parameter int DATA_W = 16,
  parameter int POT_W = 12,
  parameter int XFADE_LEN = 256,
  parameter int SEL_W = $clog2(NUM_FX)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              valid,
  input  logic [CHANNELS*DATA_W-1:0]        dry_in,
  input  logic [NUM_FX*CHANNELS*DATA_W-1:0] fx_in,
  input  logic [SEL_W-1:0]                  fx_sel,
  input  logic [POT_W-1:0]                  mix_pot,
  output logic [CHANNELS*DATA_W-1:0]        audio_out,
  output logic                              out_valid,
  output logic [SEL_W-1:0]                  active_sel,
  output logic                              fading
);
  localparam int XS = $clog2(XFADE_LEN);
  localparam int CW = DATA_W + XS + 1;
  localparam int MW = DATA_W + POT_W + 2;
  typedef enum logic {IDLE, FADE} state_t;
  state_t state, state_n;
  logic [XS-1:0] cnt, cnt_n, cur_cnt;
  logic [SEL_W-1:0] next_sel, next_sel_n, active_sel_n, new_sel;
  logic start, in_fade, v1;
  logic [XS:0] w_new, w_old;
  logic signed [CW-1:0] xw_old, xw_new;
  logic [CHANNELS*DATA_W-1:0] wet_d, wet_q, dry_q, mix_d;
  logic [POT_W-1:0] pot_q;
  logic [POT_W:0] p;
  logic signed [MW-1:0] pw, pd;
  assign start = state == IDLE && valid && fx_sel != active_sel && 32'(fx_sel) < NUM_FX;
  assign in_fade = state == FADE || start;
  assign new_sel = state == FADE ? next_sel : fx_sel;
  assign cur_cnt = state == FADE ? cnt : '0;
  assign w_new = {1'b0, cur_cnt};
  assign w_old = (XS+1)'(XFADE_LEN) - w_new;
  assign xw_old = CW'(w_old);
  assign xw_new = CW'(w_new);
  assign fading = state == FADE;
  // a pot at full scale maps to exactly 2^POT_W so the wet endpoint is exact
  assign p = &pot_q ? {1'b1, {POT_W{1'b0}}} : {1'b0, pot_q};
  assign pw = MW'(p);
  assign pd = MW'({1'b1, {POT_W{1'b0}}} - p);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    next_sel_n = next_sel;
    active_sel_n = active_sel;
    if (start) begin
      state_n = FADE;
      next_sel_n = fx_sel;
      cnt_n = XS'(1);
    end else if (valid && state == FADE) begin
      cnt_n = cnt + 1'b1;
      if (cnt == XS'(XFADE_LEN - 1)) begin
        state_n = IDLE;
        active_sel_n = next_sel;
        cnt_n = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      next_sel <= '0;
      active_sel <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      next_sel <= next_sel_n;
      active_sel <= active_sel_n;
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [DATA_W-1:0] old_s, new_s, dry_s, wet_s;
    logic signed [CW-1:0] xf;
    logic signed [MW-1:0] mx;
    assign old_s = fx_in[(32'(active_sel) * CHANNELS + c) * DATA_W +: DATA_W];
    assign new_s = fx_in[(32'(new_sel) * CHANNELS + c) * DATA_W +: DATA_W];
    assign xf = CW'(old_s) * xw_old + CW'(new_s) * xw_new;
    assign wet_d[c*DATA_W +: DATA_W] = in_fade ? DATA_W'(xf >>> XS) : old_s;
    assign dry_s = dry_q[c*DATA_W +: DATA_W];
    assign wet_s = wet_q[c*DATA_W +: DATA_W];
    assign mx = MW'(dry_s) * pd + MW'(wet_s) * pw;
    assign mix_d[c*DATA_W +: DATA_W] = DATA_W'(mx >>> POT_W);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      wet_q <= '0;
      dry_q <= '0;
      pot_q <= '0;
      audio_out <= '0;
      out_valid <= 1'b0;
    end else begin
      v1 <= valid;
      out_valid <= v1;
      if (valid) begin
        wet_q <= wet_d;
        dry_q <= dry_in;
        pot_q <= mix_pot;
      end
      if (v1) audio_out <= mix_d;
    end
  end
endmodule

// File: tb/tb_fx_select_xfade.sv
// tb_fx_select_xfade: randomized self-checking bench with a behavioural integer model of select/crossfade/mix.
module tb_fx_select_xfade;
  localparam int NF = 5;
  localparam int L = 4;
  logic clk = 0, rst = 0, valid = 0;
  logic [31:0] dry_in = '0;
  logic [NF*32-1:0] fx_in = '0;
  logic [2:0] fx_sel = '0;
  logic [11:0] mix_pot = '0;
  logic [31:0] audio_out;
  logic out_valid, fading;
  logic [2:0] active_sel;
  fx_select_xfade #(.NUM_FX(NF), .CHANNELS(2), .DATA_W(16), .POT_W(12), .XFADE_LEN(L)) dut (
    .clk(clk), .rst(rst), .valid(valid), .dry_in(dry_in), .fx_in(fx_in), .fx_sel(fx_sel),
    .mix_pot(mix_pot), .audio_out(audio_out), .out_valid(out_valid), .active_sel(active_sel), .fading(fading)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  logic [31:0] got_q[$], exp_q[$];
  int got_c[$], exp_c[$];
  always @(negedge clk) if (out_valid) begin
    got_q.push_back(audio_out);
    got_c.push_back(cyc);
  end
  int dry[2];
  int fx[NF][2];
  int m_act, m_next, m_cnt;
  bit m_fade;
  int checks = 0, errors = 0;

  function automatic int fdiv(input int a, input int b);
    return (a >= 0) ? a / b : -((-a + b - 1) / b);
  endfunction

  task automatic clear_q();
    got_q.delete(); got_c.delete(); exp_q.delete(); exp_c.delete();
  endtask

  task automatic model_reset();
    m_act = 0; m_next = 0; m_cnt = 0; m_fade = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; valid = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
    clear_q();
  endtask

  task automatic rnd_inputs();
    for (int c = 0; c < 2; c++) begin
      dry[c] = int'($signed(16'($urandom)));
      for (int s = 0; s < NF; s++) fx[s][c] = int'($signed(16'($urandom)));
    end
  endtask

  task automatic send(input int sel, input int pot);
    logic [31:0] e;
    int w, o, p;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      dry_in[c*16 +: 16] = 16'(dry[c]);
      for (int s = 0; s < NF; s++) fx_in[(s*2+c)*16 +: 16] = 16'(fx[s][c]);
    end
    fx_sel = 3'(sel);
    mix_pot = 12'(pot);
    valid = 1;
    if (!m_fade && sel != m_act && sel < NF) begin
      m_fade = 1; m_next = sel; m_cnt = 0;
    end
    p = (pot == 4095) ? 4096 : pot;
    for (int c = 0; c < 2; c++) begin
      w = m_fade ? fdiv(fx[m_act][c] * (L - m_cnt) + fx[m_next][c] * m_cnt, L) : fx[m_act][c];
      o = fdiv(dry[c] * (4096 - p) + w * p, 4096);
      e[c*16 +: 16] = 16'(o);
    end
    if (m_fade) begin
      m_cnt++;
      if (m_cnt == L) begin m_act = m_next; m_fade = 0; end
    end
    exp_q.push_back(e);
    exp_c.push_back(cyc + 2);
    @(posedge clk);
    #1 valid = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    repeat (3) @(posedge clk);
    #1 checks++;
    if ({audio_out, out_valid, active_sel, fading} !== '0) begin
      errors++;
      $display("FAIL reset_hold: out=%h ov=%b sel=%0d fad=%b want all 0", audio_out, out_valid, active_sel, fading);
    end
    rst = 0;
    repeat (2) @(posedge clk);
    #1 checks++;
    if ({audio_out, out_valid, active_sel, fading} !== '0) begin
      errors++;
      $display("FAIL reset_idle: out=%h ov=%b sel=%0d fad=%b want all 0", audio_out, out_valid, active_sel, fading);
    end
    model_reset();
    clear_q();
  endtask

  task automatic test_passthrough();
    do_reset();
    rnd_inputs();
    dry[0] = -292; dry[1] = 4660;
    send(0, 0);
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 32'h1234FEDC || got_c[0] != exp_c[0]) begin
      errors++;
      $display("FAIL passthrough: n=%0d out=%h @%0d want 1 x 1234fedc @%0d", got_q.size(),
               got_q.size() ? got_q[0] : 32'h0, got_c.size() ? got_c[0] : -1, exp_c[0]);
    end
  endtask

  task automatic test_mix();
    do_reset();
    rnd_inputs();
    fx[0][0] = 1000; fx[0][1] = -1000;
    send(0, 4095);
    dry[0] = 0; dry[1] = 0; fx[0][0] = 1000; fx[0][1] = -1001;
    send(0, 2048);
    for (int i = 0; i < 6; i++) begin
      rnd_inputs();
      send(0, $urandom_range(0, 4095));
    end
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() != exp_q.size() || got_q[0] !== 32'hFC1803E8 || got_q[1] !== 32'hFE0B01F4) begin
      errors++;
      $display("FAIL mix_endpoints: n=%0d out0=%h out1=%h want fc1803e8 fe0b01f4", got_q.size(),
               got_q.size() > 0 ? got_q[0] : 32'h0, got_q.size() > 1 ? got_q[1] : 32'h0);
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_c[i] != exp_c[i]) begin
        errors++;
        $display("FAIL mix[%0d]: out=%h @%0d want %h @%0d", i, got_q[i], got_c[i], exp_q[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_crossfade();
    int xe[5] = '{4000, 2000, 0, -2000, -4000};
    bit fe[5] = '{1, 1, 1, 0, 0};
    int ae[5] = '{0, 0, 0, 2, 2};
    do_reset();
    rnd_inputs();
    fx[0][0] = 4000; fx[0][1] = 4000; fx[2][0] = -4000; fx[2][1] = -4000;
    for (int i = 0; i < 5; i++) begin
      send(2, 4095);
      checks++;
      if (fading !== fe[i] || int'(active_sel) != ae[i]) begin
        errors++;
        $display("FAIL xfade_state[%0d]: fading=%b sel=%0d want %b %0d", i, fading, active_sel, fe[i], ae[i]);
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() != 5) begin
      errors++;
      $display("FAIL xfade_count: got %0d want 5", got_q.size());
    end
    foreach (got_q[i]) if (i < 5) begin
      checks++;
      if (int'($signed(got_q[i][15:0])) != xe[i] || int'($signed(got_q[i][31:16])) != xe[i] || got_c[i] != exp_c[i]) begin
        errors++;
        $display("FAIL xfade[%0d]: out=%h @%0d want %0d both ch @%0d", i, got_q[i], got_c[i], xe[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_midfade();
    int seq[6] = '{1, 3, 3, 3, 3, 3};
    bit fe[6] = '{1, 1, 1, 0, 1, 1};
    int ae[6] = '{0, 0, 0, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rnd_inputs();
      send(seq[i], $urandom_range(0, 4095));
      checks++;
      if (fading !== fe[i] || int'(active_sel) != ae[i]) begin
        errors++;
        $display("FAIL midfade_state[%0d]: fading=%b sel=%0d want %b %0d", i, fading, active_sel, fe[i], ae[i]);
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midfade_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_c[i] != exp_c[i]) begin
        errors++;
        $display("FAIL midfade[%0d]: out=%h @%0d want %h @%0d", i, got_q[i], got_c[i], exp_q[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_edge();
    do_reset();
    rnd_inputs();
    send(5, 100);
    send(7, 100);
    checks++;
    if (fading !== 1'b0 || active_sel !== 3'd0) begin
      errors++;
      $display("FAIL out_of_range_sel: fading=%b sel=%0d want 0 0", fading, active_sel);
    end
    send(2, 100);
    send(2, 100);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1 checks++;
    if (fading !== 1'b0 || active_sel !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_midfade: fading=%b sel=%0d ov=%b want 0 0 0", fading, active_sel, out_valid);
    end
    rst = 0;
    model_reset();
    clear_q();
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL rst_flush: got %0d outputs after reset want 0", got_q.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rnd_inputs();
    for (int i = 0; i < 8; i++) begin
      dry[0] = i * 100 - 300; dry[1] = -i * 37;
      send(0, 0);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 8", got_q.size());
    end
    foreach (got_q[i]) if (i < 8) begin
      checks++;
      if (int'($signed(got_q[i][15:0])) != i * 100 - 300 || int'($signed(got_q[i][31:16])) != -i * 37 || got_c[i] != exp_c[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: out=%h @%0d want %0d,%0d @%0d", i, got_q[i], got_c[i], -i * 37, i * 100 - 300, exp_c[i]);
      end
    end
  endtask

  task automatic test_random();
    int r, pot;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      rnd_inputs();
      r = $urandom_range(0, 9);
      pot = (r == 0) ? 0 : (r == 1) ? 4095 : $urandom_range(0, 4095);
      send($urandom_range(0, 7), pot);
      checks++;
      if (fading !== m_fade || int'(active_sel) != m_act) begin
        errors++;
        $display("FAIL rand_state[%0d]: fading=%b sel=%0d want %b %0d", i, fading, active_sel, m_fade, m_act);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_c[i] != exp_c[i]) begin
        errors++;
        $display("FAIL rand[%0d]: out=%h @%0d want %h @%0d", i, got_q[i], got_c[i], exp_q[i], exp_c[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_mix();
    test_crossfade();
    test_midfade();
    test_edge();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
